// File: rtl/ans_sym_sched.sv
// ============================================================================
// Module   : ans_sym_sched
// Brief    : Four-requester round-robin symbol scheduler feeding an ANS
//            encoder through a single registered output stage.
//            Optional per-frame burst locking is enabled by defining the
//            macro ANS_BURST_LOCK_EN. Symbol width comes from `SYM_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SYM_WIDTH
`define SYM_WIDTH 8
`endif

module ans_sym_sched #(
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*`SYM_WIDTH-1:0] req_sym,
    input  logic [3:0]              req_vld,
    output logic [3:0]              req_rdy,
    input  logic [3:0]              req_last,
    output logic [`SYM_WIDTH-1:0]   enc_sym,
    output logic [1:0]              enc_id,
    output logic                    enc_last,
    output logic                    enc_vld,
    input  logic                    enc_rdy,
    output logic                    busy
);

    localparam int c_SYM_W = `SYM_WIDTH;

    // Elaboration-time guard on the burst limit range.
    generate
        if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
            $error("ans_sym_sched: MAX_BURST must be within 1..255");
        end
    endgenerate

    logic [c_SYM_W-1:0] r_sym;
    logic [1:0]         r_id;
    logic               r_last;
    logic               r_vld;
    logic [1:0]         r_ptr;

    logic               w_load_en;
    logic               w_gnt_vld;
    logic [1:0]         w_gnt;
    logic               w_xfer;

`ifdef ANS_BURST_LOCK_EN
    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t r_state;
    logic [1:0]  r_owner;
    logic [7:0]  r_cnt;
`endif

    // The output register may take a new symbol when empty or being drained.
    assign w_load_en = !r_vld || enc_rdy;

    // Rotating-priority grant starting at r_ptr; a held lock pins the owner.
    always_comb begin
        logic [1:0] v_idx;
        w_gnt_vld = 1'b0;
        w_gnt     = r_ptr;
        v_idx     = r_ptr;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int k = 3; k >= 0; k--) begin
            v_idx = r_ptr + 2'(k);
            if (req_vld[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = v_idx;
            end
        end
`ifdef ANS_BURST_LOCK_EN
        if (r_state == ST_LOCKED) begin
            w_gnt     = r_owner;
            w_gnt_vld = req_vld[r_owner];
        end
`endif
    end

    // Only the granted requester sees ready; everyone is held off in reset.
    assign w_xfer  = w_gnt_vld && w_load_en && !rst;
    assign req_rdy = w_xfer ? (4'b0001 << w_gnt) : 4'b0000;

    // Output register stage: load on transfer, clear when drained empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sym  <= '0;
            r_id   <= 2'd0;
            r_last <= 1'b0;
            r_vld  <= 1'b0;
            r_ptr  <= 2'd0;
        end else begin
            if (w_xfer) begin
                r_sym  <= req_sym[w_gnt*c_SYM_W +: c_SYM_W];
                r_id   <= w_gnt;
                r_last <= req_last[w_gnt];
                r_vld  <= 1'b1;
                r_ptr  <= w_gnt + 2'd1;
            end else if (enc_rdy) begin
                r_vld  <= 1'b0;
            end
        end
    end

`ifdef ANS_BURST_LOCK_EN
    // Burst lock: hold the grant on one requester until end-of-frame or limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UNLOCKED;
            r_owner <= 2'd0;
            r_cnt   <= 8'd0;
        end else if (w_xfer) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (!req_last[w_gnt] && (MAX_BURST > 1)) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_gnt;
                        r_cnt   <= 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (req_last[w_gnt] || (r_cnt + 8'd1 == c_MAX_BURST)) begin
                        r_state <= ST_UNLOCKED;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_UNLOCKED;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign busy = r_vld || (r_state == ST_LOCKED);
`else
    assign busy = r_vld;
`endif

    assign enc_sym  = r_sym;
    assign enc_id   = r_id;
    assign enc_last = r_last;
    assign enc_vld  = r_vld;

endmodule

`default_nettype wire

// File: doc/ans_sym_sched.md
ANS_SYM_SCHED -- requirements
Module: ans_sym_sched

Interface
REQ-001 SHALL have parameter: MAX_BURST, 8, max symbols per locked grant (range 1..255; used only with ANS_BURST_LOCK_EN).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_sym  in  4*`SYM_WIDTH  symbol of requester i in bits [i*`SYM_WIDTH +: `SYM_WIDTH].
REQ-005 SHALL have port: req_vld  in  4  per-requester symbol valid.
REQ-006 SHALL have port: req_rdy  out  4  per-requester ready, combinational.
REQ-007 SHALL have port: req_last  in  4  per-requester end-of-frame flag, qualified by req_vld.
REQ-008 SHALL have port: enc_sym  out  `SYM_WIDTH  registered symbol to encoder.
REQ-009 SHALL have port: enc_id  out  2  registered source requester index.
REQ-010 SHALL have port: enc_last  out  1  registered copy of accepted req_last.
REQ-011 SHALL have port: enc_vld  out  1  registered output valid.
REQ-012 SHALL have port: enc_rdy  in  1  encoder ready.
REQ-013 SHALL have port: busy  out  1  enc_vld OR burst lock held.

Function
REQ-014 SHALL hold one output register stage; load_en = !enc_vld || enc_rdy.
REQ-015 SHALL select grant combinationally: first i with req_vld[i]=1 searching ptr, ptr+1, ... mod 4; no grant when req_vld=0.
REQ-016 SHALL drive req_rdy[g]=load_en for granted g only; all other req_rdy bits 0; req_rdy SHALL not depend on req_sym or req_last.
REQ-017 SHALL on transfer (req_vld[g] && req_rdy[g]) load enc_sym, enc_id=g, enc_last=req_last[g], set enc_vld=1 at same edge (latency 1 cycle).
REQ-018 SHALL clear enc_vld when enc_rdy=1 and no new transfer that cycle; enc_* hold value while enc_vld=1 and enc_rdy=0.
REQ-019 SHALL sustain 1 symbol/cycle when enc_rdy held 1 (drain and load same edge).
REQ-020 SHALL, per transfer from g (unlocked mode), set ptr=(g+1) mod 4; ptr unchanged on cycles without transfer.
REQ-021 SHALL never duplicate or drop a symbol; each accepted symbol appears exactly once on enc_* with enc_vld=1.

Reset
REQ-022 SHALL, while rst=1 asynchronously, force enc_vld=0, enc_sym=0, enc_id=0, enc_last=0, ptr=0, lock state UNLOCKED, burst count 0.
REQ-023 SHALL drop a symbol held in the output register when rst asserts mid-operation; no partial state survives.
REQ-024 SHALL drive req_rdy=0 while rst=1.

Configuration
REQ-025 SHALL implement burst locking only when macro ANS_BURST_LOCK_EN is defined; without it req_last is passed through to enc_last but never affects arbitration, and MAX_BURST is unused.
REQ-026 SHALL, with ANS_BURST_LOCK_EN, use FSM UNLOCKED/LOCKED: UNLOCKED -> LOCKED(owner=g, cnt=1) on transfer with req_last=0 and MAX_BURST>1; otherwise stay UNLOCKED.
REQ-027 SHALL in LOCKED grant only owner (other req_rdy=0 even if owner req_vld=0); each owner transfer increments cnt.
REQ-028 SHALL exit LOCKED -> UNLOCKED, ptr=(owner+1) mod 4, on owner transfer with req_last=1 or when that transfer makes cnt=MAX_BURST; cnt reset to 0.

Verification
REQ-029 SHALL cover: all 4 req_vld=1, enc_rdy=1 constant, lock disabled -> enc_id sequence 0,1,2,3,0 on consecutive cycles, one symbol per cycle.
REQ-030 SHALL cover: req 2 only, enc_rdy=0 for 3 cycles after first transfer -> enc_vld stays 1, enc_sym stable, req_rdy[2]=0 for those cycles, second symbol accepted same cycle enc_rdy returns 1.
REQ-031 SHALL cover: lock enabled, req 1 sends 3 symbols last=0,0,1 while req 0,2 valid -> enc_id 1,1,1 then 2.
REQ-032 SHALL cover: lock enabled, MAX_BURST=2, req 3 streams last=0 continuously with req 0 valid -> enc_id 3,3,0,3,3,0.
REQ-033 SHALL cover: rst pulsed while enc_vld=1 and LOCKED -> enc_vld=0 immediately, next grant from ptr=0 after release.
